// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and the datapath muxes it drives.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control word decoder for the multicycle MIPS controller.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_FOUR;
                // IR and PC only load when the instruction word actually arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALU_SRC_B_IMM_SH2;
                ctrl.illegal_op = !op_legal(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath with memory-ready watchdog.
//  state     | meaning
//  FETCH     | read instruction at PC, PC += 4 on mem_ready
//  DECODE    | compute branch target, dispatch on opcode
//  MEM_ADDR  | effective address for lw/sw
//  MEM_RD    | data read, wait for mem_ready
//  MEM_WB    | MDR -> rt
//  MEM_WR    | data write, wait for mem_ready
//  EXEC      | R-type ALU operation
//  R_WB      | ALUOut -> rd
//  BRANCH    | compare, conditional PC load
//  JUMP      | PC <- jump target
//  ADDI_EXEC | A + imm
//  ADDI_WB   | ALUOut -> rt
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_o
);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        mem_wait;
    logic        timeout;
    ctrl_t       ctrl, ctrl_gated;

    assign mem_wait = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                      && !mem_ready;
    // Fires on the MEM_TIMEOUT-th consecutive wait cycle; a same-cycle mem_ready suppresses it
    assign timeout  = mem_wait && (wait_cnt >= 16'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI_EXEC;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    state_nxt = S_MEM_WB;
                else if (timeout) state_nxt = S_FETCH;
            end
            S_MEM_WR: if (mem_ready || timeout) state_nxt = S_FETCH;
            S_EXEC:      state_nxt = S_R_WB;
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_nxt = S_FETCH;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (mem_wait && !timeout) ? wait_cnt + 16'd1 : 16'd0;
            if (timeout) mem_err <= 1'b1;
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Reset silences every enable and select combinationally, even between clock edges
    assign ctrl_gated = rst ? '0 : ctrl;

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign iord          = ctrl_gated.iord;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign reg_write     = ctrl_gated.reg_write;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_source     = ctrl_gated.pc_source;
    assign illegal_op    = ctrl_gated.illegal_op;
    assign state_o       = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed per-cycle vectors, monitor compares on negedge.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_err;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Word order: pcw pcc iord mrd mwr irw m2r rdst rwr asa | asb | aop | psrc | ill
    localparam logic [16:0] W_ZERO      = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] W_FETCH_RDY = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] W_FETCH_WT  = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] W_DECODE    = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] W_DEC_ILL   = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] W_MEM_ADDR  = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] W_MEM_RD    = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] W_MEM_WB    = 17'b0000001010_00_00_00_0;
    localparam logic [16:0] W_MEM_WR    = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] W_EXEC      = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] W_R_WB      = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] W_BRANCH    = 17'b0100000001_00_01_01_0;
    localparam logic [16:0] W_JUMP      = 17'b1000000000_00_00_10_0;
    localparam logic [16:0] W_ADDI_WB   = 17'b0000000010_00_00_00_0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] w;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic rdy, input logic [3:0] st, input logic [16:0] w,
                        input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        e.tag = tag; e.st = st; e.w = w; e.err = err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [16:0] act;
            e   = q.pop_front();
            act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op};
            total++;
            if (state_o !== e.st || act !== e.w || mem_err !== e.err) begin
                bad++;
                $display("FAIL %s: got state=%0d word=%b err=%b, want state=%0d word=%b err=%b",
                         e.tag, state_o, act, mem_err, e.st, e.w, e.err);
            end
        end
    end

    initial begin
        // reset, then reset asserted in the middle of DECODE
        step("rst_hold",     1, 6'h23, 1, 4'd0, W_ZERO,      0);
        step("rel_fetch",    0, 6'h23, 1, 4'd0, W_FETCH_RDY, 0);
        step("pre_decode",   0, 6'h23, 1, 4'd1, W_DECODE,    0);
        step("rst_mid_dec",  1, 6'h23, 1, 4'd0, W_ZERO,      0);
        step("rst_hold2",    1, 6'h23, 1, 4'd0, W_ZERO,      0);
        // lw, 5 cycles
        step("lw_fetch",     0, 6'h23, 1, 4'd0, W_FETCH_RDY, 0);
        step("lw_decode",    0, 6'h23, 1, 4'd1, W_DECODE,    0);
        step("lw_addr",      0, 6'h23, 1, 4'd2, W_MEM_ADDR,  0);
        step("lw_rd",        0, 6'h23, 1, 4'd3, W_MEM_RD,    0);
        step("lw_wb",        0, 6'h23, 1, 4'd4, W_MEM_WB,    0);
        // beq, 3 cycles
        step("beq_fetch",    0, 6'h04, 1, 4'd0, W_FETCH_RDY, 0);
        step("beq_decode",   0, 6'h04, 1, 4'd1, W_DECODE,    0);
        step("beq_branch",   0, 6'h04, 1, 4'd8, W_BRANCH,    0);
        // j, 3 cycles
        step("j_fetch",      0, 6'h02, 1, 4'd0, W_FETCH_RDY, 0);
        step("j_decode",     0, 6'h02, 1, 4'd1, W_DECODE,    0);
        step("j_jump",       0, 6'h02, 1, 4'd9, W_JUMP,      0);
        // R-type
        step("r_fetch",      0, 6'h00, 1, 4'd0, W_FETCH_RDY, 0);
        step("r_decode",     0, 6'h00, 1, 4'd1, W_DECODE,    0);
        step("r_exec",       0, 6'h00, 1, 4'd6, W_EXEC,      0);
        step("r_wb",         0, 6'h00, 1, 4'd7, W_R_WB,      0);
        // addi, with two stalled fetch cycles first
        step("ad_fetch_w1",  0, 6'h08, 0, 4'd0, W_FETCH_WT,  0);
        step("ad_fetch_w2",  0, 6'h08, 0, 4'd0, W_FETCH_WT,  0);
        step("ad_fetch",     0, 6'h08, 1, 4'd0, W_FETCH_RDY, 0);
        step("ad_decode",    0, 6'h08, 1, 4'd1, W_DECODE,    0);
        step("ad_exec",      0, 6'h08, 1, 4'd10, W_MEM_ADDR, 0);
        step("ad_wb",        0, 6'h08, 1, 4'd11, W_ADDI_WB,  0);
        // sw with three stalled write cycles
        step("sw_fetch",     0, 6'h2B, 1, 4'd0, W_FETCH_RDY, 0);
        step("sw_decode",    0, 6'h2B, 1, 4'd1, W_DECODE,    0);
        step("sw_addr",      0, 6'h2B, 1, 4'd2, W_MEM_ADDR,  0);
        step("sw_wr_w1",     0, 6'h2B, 0, 4'd5, W_MEM_WR,    0);
        step("sw_wr_w2",     0, 6'h2B, 0, 4'd5, W_MEM_WR,    0);
        step("sw_wr_w3",     0, 6'h2B, 0, 4'd5, W_MEM_WR,    0);
        step("sw_wr_done",   0, 6'h2B, 1, 4'd5, W_MEM_WR,    0);
        // lw where mem_ready arrives exactly on the timeout cycle
        step("tie_fetch",    0, 6'h23, 1, 4'd0, W_FETCH_RDY, 0);
        step("tie_decode",   0, 6'h23, 1, 4'd1, W_DECODE,    0);
        step("tie_addr",     0, 6'h23, 1, 4'd2, W_MEM_ADDR,  0);
        step("tie_rd_w1",    0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("tie_rd_w2",    0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("tie_rd_w3",    0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("tie_rd_rdy",   0, 6'h23, 1, 4'd3, W_MEM_RD,    0);
        step("tie_wb",       0, 6'h23, 1, 4'd4, W_MEM_WB,    0);
        // illegal opcode
        step("ill_fetch",    0, 6'h3F, 1, 4'd0, W_FETCH_RDY, 0);
        step("ill_decode",   0, 6'h3F, 1, 4'd1, W_DEC_ILL,   0);
        step("ill_back",     0, 6'h3F, 0, 4'd0, W_FETCH_WT,  0);
        // lw that times out in MEM_RD
        step("to_fetch",     0, 6'h23, 1, 4'd0, W_FETCH_RDY, 0);
        step("to_decode",    0, 6'h23, 1, 4'd1, W_DECODE,    0);
        step("to_addr",      0, 6'h23, 1, 4'd2, W_MEM_ADDR,  0);
        step("to_rd_w1",     0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("to_rd_w2",     0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("to_rd_w3",     0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("to_rd_w4",     0, 6'h23, 0, 4'd3, W_MEM_RD,    0);
        step("to_fetch_err", 0, 6'h23, 0, 4'd0, W_FETCH_WT,  1);
        step("to_sticky",    0, 6'h02, 1, 4'd0, W_FETCH_RDY, 1);
        step("to_after_dec", 0, 6'h02, 1, 4'd1, W_DECODE,    1);
        // reset clears the sticky error
        step("rst_clr_err",  1, 6'h00, 0, 4'd0, W_ZERO,      0);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
